// File: rtl/x_scale_pkg.sv
// Shared types and constants for the x-scale coefficient table reader.
// Build option: X_SCALE_RD_OUTREG_EN selects the ROM with an output register (read latency 2).
package x_scale_pkg;

  localparam int unsigned X_SCALE_ADDR_W = 11;
  localparam int unsigned X_SCALE_DATA_W = 15;
  localparam int unsigned X_SCALE_FIFO_DEPTH = 4;

`ifdef X_SCALE_RD_OUTREG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_e;

endpackage

// File: rtl/x_scale_rd_fifo.sv
// 4-entry synchronous FIFO of {last, data} words with an occupancy count.
module x_scale_rd_fifo #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata_c,
  output logic [2:0]   o_count
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_rd;
  logic          w_wr;

  assign w_rd      = i_rd && (r_count != '0);
  assign w_wr      = i_wr && ((r_count != CW'(DEPTH)) || w_rd);
  assign o_rdata_c = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/x_scale_rd.sv
// Streams a wrapping address range of the x-scale coefficient ROM out on valid/ready.
// Build option: X_SCALE_RD_OUTREG_EN (ROM output register, read latency 2 instead of 1).
module x_scale_rd
  import x_scale_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = X_SCALE_ADDR_W,
  parameter int unsigned DATA_WIDTH = X_SCALE_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_base,
  input  logic [ADDR_WIDTH:0]   start_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned LW   = ADDR_WIDTH + 1;
  localparam int unsigned CW   = 3;
  localparam int unsigned EW   = DATA_WIDTH + 1;
  localparam int unsigned CRED = X_SCALE_FIFO_DEPTH;

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [LW-1:0]         r_remain;
  logic [RD_LAT-1:0]     r_pipe_vld;
  logic [RD_LAT-1:0]     r_pipe_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_last_hs;
  logic                  w_fifo_rd;
  logic [CW-1:0]         w_in_flight;
  logic [CW-1:0]         w_fifo_count;
  logic [EW-1:0]         w_fifo_rdata;

  // Credit: words in the ROM pipe plus words queued must leave room in the FIFO
  assign w_in_flight  = CW'($countones(r_pipe_vld));
  assign w_credit     = ({1'b0, w_in_flight} + {1'b0, w_fifo_count}) < (CW + 1)'(CRED);
  assign w_issue      = (r_state == ISSUE) && w_credit;
  assign w_issue_last = w_issue && (r_remain == LW'(1));
  assign w_last_hs    = r_m_valid && m_ready && r_m_last;
  assign w_fifo_rd    = (w_fifo_count != '0) && (!r_m_valid || m_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus next busy/done.
  // done is raised on the last handshake for a normal command; a zero-length
  // command enters FINISH with done low, so FINISH raises it only if not already high.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_busy_nxt  = 1'b1;
          w_state_nxt = (start_len == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        w_busy_nxt = 1'b1;
        if (w_issue_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_last_hs) begin
          w_state_nxt = FINISH;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
        w_done_nxt  = ~r_done;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Command latch and address issue (address wraps naturally at 2**ADDR_WIDTH)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_rom_addr <= '0;
      r_remain   <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_addr   <= start_base;
      r_remain <= start_len;
    end else if (w_issue) begin
      r_rom_addr <= r_addr;
      r_addr     <= r_addr + ADDR_WIDTH'(1);
      r_remain   <= r_remain - LW'(1);
    end
  end

  // In-flight pipe: issue flag and last tag ride alongside the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  x_scale_rd_fifo #(
    .W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (r_pipe_vld[RD_LAT-1]),
    .i_wdata   ({r_pipe_last[RD_LAT-1], rom_rd_data}),
    .i_rd      (w_fifo_rd),
    .o_rdata_c (w_fifo_rdata),
    .o_count   (w_fifo_count)
  );

  // Output register: loads when empty or being accepted, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_fifo_rd) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_fifo_rdata[DATA_WIDTH-1:0];
      r_m_last  <= w_fifo_rdata[DATA_WIDTH];
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_addr = r_rom_addr;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_last   = r_m_last;

endmodule

// File: tb/tb_x_scale_rd.sv
// Self-checking bench for x_scale_rd with a behavioural ROM and expected-stream model.
`timescale 1ns/1ps
module tb_x_scale_rd;
  import x_scale_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 15;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_base = '0;
  logic [AW:0]   start_len = '0;
  logic          busy, done, m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data, m_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom_mem [DEPTH];

  always #5 clk = ~clk;

`ifdef X_SCALE_RD_OUTREG_EN
  logic [DW-1:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_rd_data = rom_q;
`else
  assign rom_rd_data = rom_mem[rom_addr];
`endif

  x_scale_rd dut (
    .clk (clk), .rst_n (rst_n), .start (start), .start_base (start_base),
    .start_len (start_len), .busy (busy), .done (done), .rom_addr (rom_addr),
    .rom_rd_data (rom_rd_data), .m_valid (m_valid), .m_ready (m_ready),
    .m_data (m_data), .m_last (m_last)
  );

  // Observations from one command
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic          busy_q[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];
  int first_valid_edge, done_edge, done_pulses, hs_last_edge, max_out, stab_err, n_valid;
  bit timeout;

  // Expected stream: len words from base upward, wrapping, last on the final one
  task automatic build_exp(input logic [AW-1:0] base, input logic [AW:0] len);
    exp_d.delete(); exp_l.delete();
    for (int i = 0; i < int'(len); i++) begin
      exp_d.push_back(rom_mem[AW'(int'(base) + i)]);
      exp_l.push_back(i == int'(len) - 1);
    end
  endtask

  function automatic int stream_bad();
    int n = 0;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) n++;
    return n;
  endfunction

  // Drive one command and record what comes out; k counts edges after the start edge
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                         input int inject_k, input int budget);
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] sd;
    logic sl, mv, stall;
    int issued, accepted, tail;
    got_d.delete(); got_l.delete(); busy_q.delete();
    first_valid_edge = -1; done_edge = -1; done_pulses = 0; hs_last_edge = -1;
    max_out = 0; stab_err = 0; n_valid = 0; timeout = 1'b0;
    prev_addr = rom_addr; issued = 0; accepted = 0; tail = -1; stall = 1'b0; sd = '0; sl = 1'b0;
    @(negedge clk);
    start = 1'b1; start_base = base; start_len = len;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == inject_k) begin
        start = 1'b1; start_base = base + 11'd100; start_len = 12'd4;
      end else if (k == inject_k + 1) begin
        start = 1'b0;
      end
      mv = m_valid;
      if (stall && (!mv || m_data !== sd || m_last !== sl)) stab_err++;
      if (mv) begin
        n_valid++;
        if (first_valid_edge < 0) first_valid_edge = k;
      end
      if (done) begin
        done_pulses++;
        if (done_edge < 0) done_edge = k;
      end
      busy_q.push_back(busy);
      if (rom_addr != prev_addr) begin
        issued++;
        prev_addr = rom_addr;
      end
      if (issued - accepted - int'(mv) > max_out) max_out = issued - accepted - int'(mv);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (mv && m_ready) begin
        got_d.push_back(m_data); got_l.push_back(m_last); accepted++;
        if (m_last) hs_last_edge = k + 1;
      end
      stall = mv && !m_ready; sd = m_data; sl = m_last;
      if (done_edge >= 0 && tail < 0) tail = 4;
      if (tail > 0) tail--;
      if (tail == 0) break;
    end
    if (done_edge < 0) timeout = 1'b1;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, rom_addr, m_valid, m_data, m_last} !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want 0", {busy, done, rom_addr, m_valid, m_data, m_last});
    end
  endtask

  task automatic test_basic();
    build_exp(11'd0, 12'd8);
    run_cmd(11'd0, 12'd8, 0, -1, 80);
    checks++;
    if (got_d.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", got_d.size()); end
    checks++;
    if (stream_bad() != 0) begin errors++; $display("FAIL basic_stream bad %0d want 0", stream_bad()); end
    checks++;
    if (first_valid_edge != 2 + int'(RD_LAT)) begin
      errors++; $display("FAIL basic_first_valid got %0d want %0d", first_valid_edge, 2 + int'(RD_LAT));
    end
    checks++;
    if (hs_last_edge != 10 + int'(RD_LAT)) begin
      errors++; $display("FAIL basic_throughput last_hs %0d want %0d", hs_last_edge, 10 + int'(RD_LAT));
    end
    checks++;
    if (timeout || done_edge != hs_last_edge) begin
      errors++; $display("FAIL basic_done_edge got %0d want %0d", done_edge, hs_last_edge);
    end
    checks++;
    if (done_pulses != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_pulses); end
    checks++;
    if (busy_q[0] !== 1'b1 || done_edge < 1 || busy_q[done_edge] !== 1'b0 || busy_q[done_edge-1] !== 1'b1) begin
      errors++; $display("FAIL basic_busy got b0=%0b done_edge=%0d want b0=1 falls at done", busy_q[0], done_edge);
    end
  endtask

  task automatic test_wrap();
    build_exp(11'd2045, 12'd5);
    run_cmd(11'd2045, 12'd5, 0, -1, 60);
    checks++;
    if (got_d.size() != 5 || stream_bad() != 0) begin
      errors++; $display("FAIL wrap_stream count %0d bad %0d want 5/0", got_d.size(), stream_bad());
    end
    checks++;
    if (timeout || got_d.size() != 5 || got_d[3] !== 15'd0 || got_d[4] !== 15'd1) begin
      errors++; $display("FAIL wrap_tail got size %0d timeout %0b want words 0,1 at end", got_d.size(), timeout);
    end
  endtask

  task automatic test_backpressure();
    build_exp(11'd300, 12'd16);
    run_cmd(11'd300, 12'd16, 1, -1, 200);
    checks++;
    if (got_d.size() != 16 || stream_bad() != 0) begin
      errors++; $display("FAIL bp_stream count %0d bad %0d want 16/0", got_d.size(), stream_bad());
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable violations %0d want 0", stab_err); end
    checks++;
    if (max_out > 4) begin errors++; $display("FAIL bp_credit max outstanding %0d want <=4", max_out); end
    checks++;
    if (timeout || done_pulses != 1 || done_edge != hs_last_edge) begin
      errors++; $display("FAIL bp_done edge %0d pulses %0d want %0d/1", done_edge, done_pulses, hs_last_edge);
    end
  endtask

  task automatic test_len_zero();
    run_cmd(11'd10, 12'd0, 0, -1, 20);
    checks++;
    if (n_valid != 0 || got_d.size() != 0) begin errors++; $display("FAIL len0_valid cycles %0d want 0", n_valid); end
    checks++;
    if (done_edge != 1 || done_pulses != 1) begin
      errors++; $display("FAIL len0_done edge %0d pulses %0d want 1/1", done_edge, done_pulses);
    end
    checks++;
    if (busy_q[0] !== 1'b1 || busy_q[1] !== 1'b0) begin
      errors++; $display("FAIL len0_busy got %0b%0b want 10", busy_q[0], busy_q[1]);
    end
  endtask

  task automatic test_start_while_busy();
    int late;
    build_exp(11'd400, 12'd6);
    run_cmd(11'd400, 12'd6, 0, 2, 80);
    late = 0;
    for (int i = (done_edge < 0 ? 0 : done_edge); i < busy_q.size(); i++) if (busy_q[i] !== 1'b0) late++;
    checks++;
    if (got_d.size() != 6 || stream_bad() != 0) begin
      errors++; $display("FAIL ignore_stream count %0d bad %0d want 6/0", got_d.size(), stream_bad());
    end
    checks++;
    if (timeout || done_pulses != 1 || late != 0) begin
      errors++; $display("FAIL ignore_done pulses %0d busy_after %0d want 1/0", done_pulses, late);
    end
  endtask

  task automatic test_full_table();
    int nlast;
    build_exp(11'd0, 12'd2048);
    run_cmd(11'd0, 12'd2048, 0, -1, 2200);
    nlast = 0;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    checks++;
    if (got_d.size() != 2048 || stream_bad() != 0) begin
      errors++; $display("FAIL full_stream count %0d bad %0d want 2048/0", got_d.size(), stream_bad());
    end
    checks++;
    if (nlast != 1 || got_l.size() != 2048 || got_d[2047] !== 15'd2047) begin
      errors++; $display("FAIL full_last count %0d want 1 on addr 2047", nlast);
    end
    checks++;
    if (timeout || done_pulses != 1 || done_edge != hs_last_edge) begin
      errors++; $display("FAIL full_done edge %0d pulses %0d want %0d/1", done_edge, done_pulses, hs_last_edge);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [AW:0]   n;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom);
    for (int t = 0; t < 6; t++) begin
      b = AW'($urandom);
      n = 12'($urandom_range(1, 40));
      build_exp(b, n);
      run_cmd(b, n, 2, -1, int'(n) * 10 + 60);
      checks++;
      if (timeout || got_d.size() != int'(n) || stream_bad() != 0 || stab_err != 0) begin
        errors++;
        $display("FAIL random_%0d base %0d len %0d got count %0d bad %0d stab %0d want %0d/0/0",
                 t, b, n, got_d.size(), stream_bad(), stab_err, n);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int acc;
    int saw_done;
    acc = 0; saw_done = 0;
    build_exp(11'd50, 12'd10);
    @(negedge clk);
    start = 1'b1; start_base = 11'd50; start_len = 12'd10; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && acc < 5; k++) begin
      if (m_valid) acc++;
      if (done) saw_done++;
      @(negedge clk);
    end
    checks++;
    if (acc < 5 || m_valid !== 1'b1 || m_data !== exp_d[5]) begin
      errors++; $display("FAIL rst_pre accepted %0d data %0d want 5 then %0d", acc, m_data, exp_d[5]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rom_addr, m_valid, m_data, m_last} !== '0) begin
      errors++; $display("FAIL rst_immediate got %h want 0", {busy, done, rom_addr, m_valid, m_data, m_last});
    end
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin errors++; $display("FAIL rst_no_done pulses %0d want 0", saw_done); end
    build_exp(11'd700, 12'd3);
    run_cmd(11'd700, 12'd3, 0, -1, 60);
    checks++;
    if (timeout || got_d.size() != 3 || stream_bad() != 0 || first_valid_edge != 2 + int'(RD_LAT)) begin
      errors++;
      $display("FAIL rst_restart count %0d bad %0d first %0d want 3/0/%0d",
               got_d.size(), stream_bad(), first_valid_edge, 2 + int'(RD_LAT));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_full_table();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
